// File: rtl/vram_dma_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vram_dma_pkg : state, register-select, control and status encodings
// Rev 1.0
// ----------------------------------------------------------------------------
package vram_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VB = 2'd1,
    ST_XFER    = 2'd2,
    ST_DRAIN   = 2'd3
  } dma_state_e;

  localparam logic [1:0] SEL_SRC  = 2'd0;
  localparam logic [1:0] SEL_DST  = 2'd1;
  localparam logic [1:0] SEL_LEN  = 2'd2;
  localparam logic [1:0] SEL_CTRL = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_TILE    = 1;
  localparam int CTRL_WAIT_VB = 2;
  localparam int CTRL_ABORT   = 3;

  localparam int STAT_BUSY    = 15;
  localparam int STAT_DONE    = 14;
  localparam int STAT_ABORTED = 13;

endpackage
`default_nettype wire

// File: rtl/vram_dma_cfg_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_cfg_regs : CPU-visible SRC/DST/LEN registers, control latch, sticky status
// Rev 1.0
// ----------------------------------------------------------------------------
module dma_cfg_regs
  import vram_dma_pkg::*;
#(
  parameter int LEN_W = 11,
  parameter int DST_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_write,
  input  logic [1:0]       cfg_sel,
  input  logic [15:0]      cfg_data,
  input  logic             busy,
  input  logic             done_set,
  input  logic             abort_set,
  output logic [15:0]      src_reg,
  output logic [DST_W-1:0] dst_reg,
  output logic [LEN_W-1:0] len_reg,
  output logic             start_req,
  output logic             start_tile,
  output logic             start_wait,
  output logic             abort_req,
  output logic             tile,
  output logic             done,
  output logic             aborted
);

  logic [15:0]      src_q, src_d;
  logic [DST_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             tile_q, tile_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             ctrl_wr;
  logic             reg_wr;

  always_comb begin
    ctrl_wr    = cfg_write && (cfg_sel == SEL_CTRL);
    reg_wr     = cfg_write && !busy;
    start_req  = ctrl_wr && cfg_data[CTRL_START] && !busy;
    abort_req  = ctrl_wr && cfg_data[CTRL_ABORT] && busy;
    start_tile = cfg_data[CTRL_TILE];
    start_wait = cfg_data[CTRL_WAIT_VB];

    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    tile_d    = tile_q;
    done_d    = done_q;
    aborted_d = aborted_q;

    if (reg_wr && (cfg_sel == SEL_SRC)) src_d = cfg_data;
    if (reg_wr && (cfg_sel == SEL_DST)) dst_d = cfg_data[DST_W-1:0];
    if (reg_wr && (cfg_sel == SEL_LEN)) len_d = cfg_data[LEN_W-1:0];

    // A new start clears the sticky flags; a zero-length start sets done in the same edge.
    if (start_req) begin
      tile_d    = cfg_data[CTRL_TILE];
      done_d    = 1'b0;
      aborted_d = 1'b0;
    end
    if (done_set)  done_d    = 1'b1;
    if (abort_set) aborted_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      tile_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      tile_q    <= tile_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign src_reg = src_q;
  assign dst_reg = dst_q;
  assign len_reg = len_q;
  assign tile    = tile_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule
`default_nettype wire

// File: rtl/vram_dma.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vram_dma : block copy from program memory into sprite or tile RAM
// Rev 1.0
// ----------------------------------------------------------------------------
module vram_dma
  import vram_dma_pkg::*;
#(
  parameter int LEN_W     = 11,
  parameter int SPRITE_AW = 10,
  parameter int TILE_AW   = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_write,
  input  logic [1:0]         cfg_sel,
  input  logic [15:0]        cfg_data,
  output logic [15:0]        status,
  input  logic               vbright,
  output logic               dma_req,
  input  logic               dma_gnt,
  output logic               src_en,
  output logic [15:0]        src_addr,
  input  logic [15:0]        src_data,
  output logic               dst_we,
  output logic               dst_tile,
  output logic [TILE_AW-1:0] dst_addr,
  output logic [15:0]        dst_data,
  output logic               done_pulse
);

  dma_state_e         state_q, state_d;
  logic [15:0]        src_cnt_q, src_cnt_d;
  logic [TILE_AW-1:0] dst_cnt_q, dst_cnt_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               wr_pend_q, wr_pend_d;
  logic               zlen_q, zlen_d;

  logic [15:0]        src_reg;
  logic [TILE_AW-1:0] dst_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               start_req, start_tile, start_wait, abort_req;
  logic               tile, done, aborted;
  logic               busy, done_set, abort_set, fin_pulse;

  function automatic logic [TILE_AW-1:0] dst_mask(input logic is_tile);
    return is_tile ? {TILE_AW{1'b1}} : TILE_AW'((1 << SPRITE_AW) - 1);
  endfunction

  dma_cfg_regs #(
    .LEN_W (LEN_W),
    .DST_W (TILE_AW)
  ) u_regs (
    .clk        (clk),
    .rst        (rst),
    .cfg_write  (cfg_write),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .busy       (busy),
    .done_set   (done_set),
    .abort_set  (abort_set),
    .src_reg    (src_reg),
    .dst_reg    (dst_reg),
    .len_reg    (len_reg),
    .start_req  (start_req),
    .start_tile (start_tile),
    .start_wait (start_wait),
    .abort_req  (abort_req),
    .tile       (tile),
    .done       (done),
    .aborted    (aborted)
  );

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    src_cnt_d = src_cnt_q;
    dst_cnt_d = dst_cnt_q;
    rem_d     = rem_q;
    zlen_d    = 1'b0;
    src_en    = 1'b0;
    dma_req   = 1'b0;
    done_set  = 1'b0;
    abort_set = 1'b0;
    fin_pulse = 1'b0;

    if (wr_pend_q) dst_cnt_d = (dst_cnt_q + TILE_AW'(1)) & dst_mask(tile);

    unique case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          src_cnt_d = src_reg;
          dst_cnt_d = dst_reg & dst_mask(start_tile);
          rem_d     = len_reg;
          if (len_reg == '0) begin
            zlen_d   = 1'b1;
            done_set = 1'b1;
          end else if (start_wait && vbright) begin
            state_d = ST_WAIT_VB;
          end else begin
            state_d = ST_XFER;
          end
        end
      end
      ST_WAIT_VB: begin
        if (abort_req) begin
          state_d   = ST_IDLE;
          abort_set = 1'b1;
        end else if (!vbright) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        dma_req = 1'b1;
        // Abort blocks the read in its own cycle; the write already in flight still lands.
        if (abort_req) begin
          state_d   = ST_IDLE;
          abort_set = 1'b1;
        end else if (dma_gnt) begin
          src_en    = 1'b1;
          src_cnt_d = src_cnt_q + 16'd1;
          rem_d     = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        if (abort_req) begin
          abort_set = 1'b1;
        end else begin
          done_set  = 1'b1;
          fin_pulse = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_pend_d = src_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      src_cnt_q <= '0;
      dst_cnt_q <= '0;
      rem_q     <= '0;
      wr_pend_q <= 1'b0;
      zlen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_cnt_q <= src_cnt_d;
      dst_cnt_q <= dst_cnt_d;
      rem_q     <= rem_d;
      wr_pend_q <= wr_pend_d;
      zlen_q    <= zlen_d;
    end
  end

  always_comb begin
    status               = '0;
    status[STAT_BUSY]    = busy;
    status[STAT_DONE]    = done;
    status[STAT_ABORTED] = aborted;
  end

  assign src_addr   = src_cnt_q;
  assign dst_we     = wr_pend_q;
  assign dst_tile   = tile;
  assign dst_addr   = dst_cnt_q;
  assign dst_data   = wr_pend_q ? src_data : 16'd0;
  assign done_pulse = fin_pulse | zlen_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_dma.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vram_dma : directed bench with a write scoreboard for vram_dma
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_vram_dma;
  import vram_dma_pkg::*;

  localparam int LEN_W     = 11;
  localparam int SPRITE_AW = 10;
  localparam int TILE_AW   = 13;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_write = 1'b0;
  logic [1:0]         cfg_sel = 2'd0;
  logic [15:0]        cfg_data = 16'd0;
  logic [15:0]        status;
  logic               vbright = 1'b1;
  logic               dma_req;
  logic               dma_gnt = 1'b0;
  logic               src_en;
  logic [15:0]        src_addr;
  logic [15:0]        src_data = 16'd0;
  logic               dst_we;
  logic               dst_tile;
  logic [TILE_AW-1:0] dst_addr;
  logic [15:0]        dst_data;
  logic               done_pulse;

  typedef struct packed {
    logic               tile;
    logic [TILE_AW-1:0] addr;
    logic [15:0]        data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  n_wr = 0, n_rd = 0, n_done = 0, n_req = 0;

  vram_dma #(
    .LEN_W     (LEN_W),
    .SPRITE_AW (SPRITE_AW),
    .TILE_AW   (TILE_AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_write  (cfg_write),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .status     (status),
    .vbright    (vbright),
    .dma_req    (dma_req),
    .dma_gnt    (dma_gnt),
    .src_en     (src_en),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .dst_we     (dst_we),
    .dst_tile   (dst_tile),
    .dst_addr   (dst_addr),
    .dst_data   (dst_data),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Program memory: registered read, poison value when not enabled.
  always @(posedge clk) src_data <= src_en ? mem(src_addr) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] sel, input logic [15:0] d);
    cfg_write = 1'b1;
    cfg_sel   = sel;
    cfg_data  = d;
    tick();
    cfg_write = 1'b0;
    cfg_data  = 16'd0;
  endtask

  task automatic clear_counts();
    n_wr = 0; n_rd = 0; n_done = 0; n_req = 0;
  endtask

  task automatic expect_block(input logic tile, input logic [15:0] src,
                              input logic [15:0] dst, input int len);
    logic [TILE_AW-1:0] m;
    logic [TILE_AW-1:0] a;
    logic [15:0]        s;
    wr_t                e;
    m = tile ? {TILE_AW{1'b1}} : TILE_AW'((1 << SPRITE_AW) - 1);
    a = TILE_AW'(dst) & m;
    s = src;
    for (int i = 0; i < len; i++) begin
      e.tile = tile;
      e.addr = a;
      e.data = mem(s);
      exp_q.push_back(e);
      s = s + 16'd1;
      a = (a + TILE_AW'(1)) & m;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (status[STAT_BUSY] && k < budget) begin
      tick();
      k++;
    end
    check(tag, {31'd0, status[STAT_BUSY]}, 32'd0);
  endtask

  // Write monitor / scoreboard consumer.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (src_en)     n_rd++;
      if (done_pulse) n_done++;
      if (dma_req)    n_req++;
      if (dst_we) begin
        n_wr++;
        check("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", {19'd0, dst_addr}, {19'd0, e.addr});
          check("wr_data", {16'd0, dst_data}, {16'd0, e.data});
          check("wr_tile", {31'd0, dst_tile}, {31'd0, e.tile});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_status",  {16'd0, status}, 32'd0);
    check("rst_req",     {31'd0, dma_req}, 32'd0);
    check("rst_src_en",  {31'd0, src_en}, 32'd0);
    check("rst_dst_we",  {31'd0, dst_we}, 32'd0);
    check("rst_done",    {31'd0, done_pulse}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic sprite copy with cycle-exact timing
    dma_gnt = 1'b1;
    cfg_wr(SEL_SRC, 16'h0100);
    cfg_wr(SEL_DST, 16'h0010);
    cfg_wr(SEL_LEN, 16'd4);
    expect_block(1'b0, 16'h0100, 16'h0010, 4);
    clear_counts();
    cfg_wr(SEL_CTRL, 16'h0001);
    check("t1_req", {31'd0, dma_req}, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      check("t1_src_en", {31'd0, src_en}, {31'd0, (i <= 4)});
      if (i <= 4) check("t1_src_addr", {16'd0, src_addr}, 32'h0100 + 32'(i - 1));
      check("t1_dst_we", {31'd0, dst_we}, {31'd0, (i >= 2 && i <= 5)});
      check("t1_done_pulse", {31'd0, done_pulse}, {31'd0, (i == 5)});
      check("t1_busy", {31'd0, status[STAT_BUSY]}, {31'd0, (i <= 5)});
      tick();
    end
    check("t1_nwr", n_wr, 4);
    check("t1_ndone", n_done, 1);
    check("t1_status", {16'd0, status}, 32'h4000);

    // Wait for vblank, tile target, destination wrap at 2^TILE_AW
    vbright = 1'b1;
    cfg_wr(SEL_SRC, 16'h0400);
    cfg_wr(SEL_DST, 16'h1FFF);
    cfg_wr(SEL_LEN, 16'd3);
    expect_block(1'b1, 16'h0400, 16'h1FFF, 3);
    clear_counts();
    cfg_wr(SEL_CTRL, 16'h0007);
    check("t2_busy", {31'd0, status[STAT_BUSY]}, 32'd1);
    repeat (20) tick();
    check("t2_nreq_vbright", n_req, 0);
    check("t2_nrd_vbright", n_rd, 0);
    vbright = 1'b0;
    wait_idle("t2_idle_timeout", 30);
    check("t2_nwr", n_wr, 3);
    check("t2_qempty", exp_q.size(), 0);
    vbright = 1'b1;

    // Toggling grant
    cfg_wr(SEL_SRC, 16'h0800);
    cfg_wr(SEL_DST, 16'h0020);
    cfg_wr(SEL_LEN, 16'd8);
    expect_block(1'b0, 16'h0800, 16'h0020, 8);
    clear_counts();
    cfg_wr(SEL_CTRL, 16'h0001);
    begin
      int k;
      k = 0;
      while (status[STAT_BUSY] && k < 60) begin
        dma_gnt = (k % 2 == 0);
        tick();
        k++;
      end
    end
    check("t3_idle", {31'd0, status[STAT_BUSY]}, 32'd0);
    dma_gnt = 1'b1;
    tick();
    check("t3_nwr", n_wr, 8);
    check("t3_nrd", n_rd, 8);
    check("t3_ndone", n_done, 1);

    // Source and sprite destination wrap
    cfg_wr(SEL_SRC, 16'hFFFE);
    cfg_wr(SEL_DST, 16'h03FE);
    cfg_wr(SEL_LEN, 16'd4);
    expect_block(1'b0, 16'hFFFE, 16'h03FE, 4);
    clear_counts();
    cfg_wr(SEL_CTRL, 16'h0001);
    wait_idle("t4_idle_timeout", 20);
    check("t4_nwr", n_wr, 4);

    // Abort after the second read
    cfg_wr(SEL_SRC, 16'h0300);
    cfg_wr(SEL_DST, 16'h0040);
    cfg_wr(SEL_LEN, 16'd6);
    expect_block(1'b0, 16'h0300, 16'h0040, 2);
    clear_counts();
    cfg_wr(SEL_CTRL, 16'h0001);
    tick();
    tick();
    cfg_wr(SEL_CTRL, 16'h0008);
    tick();
    tick();
    check("t5_status", {16'd0, status}, 32'h2000);
    check("t5_nwr", n_wr, 2);
    check("t5_nrd", n_rd, 2);
    check("t5_ndone", n_done, 0);
    check("t5_qempty", exp_q.size(), 0);

    // Zero-length start
    cfg_wr(SEL_LEN, 16'd0);
    clear_counts();
    cfg_wr(SEL_CTRL, 16'h0001);
    check("t6_done_pulse", {31'd0, done_pulse}, 32'd1);
    check("t6_status", {16'd0, status}, 32'h4000);
    tick();
    check("t6_done_pulse_clr", {31'd0, done_pulse}, 32'd0);
    tick();
    check("t6_nrd", n_rd, 0);
    check("t6_nwr", n_wr, 0);

    // Register writes while busy are ignored
    cfg_wr(SEL_SRC, 16'h0500);
    cfg_wr(SEL_DST, 16'h0050);
    cfg_wr(SEL_LEN, 16'd3);
    expect_block(1'b0, 16'h0500, 16'h0050, 3);
    clear_counts();
    cfg_wr(SEL_CTRL, 16'h0001);
    cfg_wr(SEL_SRC, 16'h0700);
    cfg_wr(SEL_LEN, 16'd5);
    wait_idle("t7a_idle_timeout", 20);
    expect_block(1'b0, 16'h0500, 16'h0050, 3);
    cfg_wr(SEL_CTRL, 16'h0001);
    wait_idle("t7b_idle_timeout", 20);
    check("t7_nwr", n_wr, 6);
    check("t7_qempty", exp_q.size(), 0);

    // Reset mid-transfer
    cfg_wr(SEL_SRC, 16'h0600);
    cfg_wr(SEL_DST, 16'h0100);
    cfg_wr(SEL_LEN, 16'd8);
    expect_block(1'b1, 16'h0600, 16'h0100, 8);
    cfg_wr(SEL_CTRL, 16'h0003);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t8_req",      {31'd0, dma_req}, 32'd0);
    check("t8_src_en",   {31'd0, src_en}, 32'd0);
    check("t8_src_addr", {16'd0, src_addr}, 32'd0);
    check("t8_dst_we",   {31'd0, dst_we}, 32'd0);
    check("t8_dst_tile", {31'd0, dst_tile}, 32'd0);
    check("t8_dst_addr", {19'd0, dst_addr}, 32'd0);
    check("t8_dst_data", {16'd0, dst_data}, 32'd0);
    check("t8_status",   {16'd0, status}, 32'd0);
    check("t8_done",     {31'd0, done_pulse}, 32'd0);
    tick();
    check("t8_req_stays_low", {31'd0, dma_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_dma.md
# vram_dma

DMA engine that copies a block of words from program memory into sprite object RAM or tile data RAM without CPU load/store loops. It sits beside the memory map: the CPU programs it through four memory-mapped registers, it requests program-memory port A from the CPU-side arbiter, and it writes the GPU RAM write ports directly. It can optionally hold off until vertical blanking so that the renderer never reads half-updated data.

## Interface
Parameters:
- LEN_W, 11, width of the length register; maximum transfer is 2^LEN_W − 1 words.
- SPRITE_AW, 10, sprite object RAM address width.
- TILE_AW, 13, tile data RAM address width.

Ports:
- clk  in  1  single clock; every register is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_write  in  1  register write strobe from the memory map.
- cfg_sel  in  2  register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL.
- cfg_data  in  16  register write data.
- status  out  16  {busy, done, aborted, 13'b0}.
- vbright  in  1  vertical active-display flag; 0 means vblank.
- dma_req  out  1  request for program-memory port A.
- dma_gnt  in  1  grant from the arbiter; may drop at any cycle.
- src_en  out  1  read enable to program memory.
- src_addr  out  16  read address.
- src_data  in  16  read data, valid one cycle after src_en.
- dst_we  out  1  write strobe to the target RAM.
- dst_tile  out  1  target select: 0 sprite RAM, 1 tile RAM.
- dst_addr  out  13  write address; only the low SPRITE_AW bits are meaningful when dst_tile=0.
- dst_data  out  16  write data.
- done_pulse  out  1  one-cycle completion pulse, for interrupt logic.

## Operation
- Registers reset to 0: SRC, DST, LEN, and the control latches.
- CTRL write bits:
  - bit0 start
  - bit1 tile target
  - bit2 wait-for-vblank
  - bit3 abort
- While busy, writes to SRC/DST/LEN and start writes are ignored. Abort is the only CTRL bit honoured while busy.
- States:
  - IDLE: start with LEN=0 pulses done_pulse next cycle and sets done, with no memory traffic. Start with wait-vblank=1 and vbright=1 goes to WAIT_VB; any other start goes to XFER.
  - WAIT_VB: dma_req stays low. Moves to XFER on the first cycle vbright=0.
  - XFER: dma_req=1. Each cycle with dma_gnt=1 asserts src_en at the current source address, then increments the source address and decrements the remaining count. When the last read issues, moves to DRAIN.
  - DRAIN: performs the final write, pulses done_pulse, sets done, and returns to IDLE.
- Write pipeline:
  - A read issued at cycle k produces dst_we=1 at cycle k+1, with dst_data=src_data and the registered destination address.
  - The destination address increments per write.
  - A read that is in flight always completes its write, even if dma_gnt has dropped.
- Address arithmetic:
  - The source address wraps modulo 2^16.
  - The destination wraps modulo 2^TILE_AW for tile RAM and modulo 2^SPRITE_AW for sprite RAM; the upper dst_addr bits are 0 for sprite RAM.
- Abort (CTRL bit3 while busy):
  - No new reads issue.
  - An in-flight write still completes.
  - The block then returns to IDLE with aborted=1, done=0, and no done_pulse.
- Status bits:
  - busy = state≠IDLE.
  - done and aborted are sticky and are cleared by the next accepted start.
  - status is combinational from registers.

## Timing
- Reset: every output is 0, and the block is in IDLE.
- A cfg write at cycle T takes effect at T+1.
- Start at T without vblank wait:
  - dma_req=1 at T+1.
  - With dma_gnt held high, reads occur at T+1…T+LEN.
  - Writes occur at T+2…T+LEN+1, and done_pulse coincides with the last write.
  - busy=0 at T+LEN+2.
- Throughput is one word per granted cycle. Each cycle without grant stalls issue by one cycle.
- Reset in the middle of a transfer takes effect immediately: the in-flight write is dropped and all state clears.

## Structure
- A shared package holds:
  - the state encoding (IDLE, WAIT_VB, XFER, DRAIN);
  - the cfg_sel codes;
  - the CTRL bit indices;
  - the status bit positions.
- One sub-module, dma_cfg_regs, holds the register file, busy-gating and sticky status. The FSM and address counters stay in vram_dma.

## Test plan
- SRC=0x0100, DST=0x0010, LEN=4, CTRL=0x1, gnt held → sprite writes to 0x010–0x013 carry mem[0x100–0x103]; done_pulse occurs with the last write; busy drops 6 cycles after start.
- CTRL=0x7 with vbright=1 for 20 cycles → no dma_req during those 20 cycles; after vbright falls, tile writes start at DST.
- LEN=8, dma_gnt toggling 1,0,1,0 → exactly 8 writes with consecutive data; no duplicated or skipped address.
- DST=0x3FE (sprite), LEN=4 → writes land at 0x3FE, 0x3FF, 0x000, 0x001; SRC=0xFFFF wraps to 0x0000.
- Abort written in the cycle after the 2nd read → exactly 2 writes; status = busy 0, done 0, aborted 1; no done_pulse.
- LEN=0 start → done_pulse one cycle later, with no src_en and no dst_we. A SRC write while busy is ignored. rst asserted mid-transfer → all outputs 0 on the next cycle.
